// File: rtl/io_timer_intc.sv
// io_timer_intc: memory-mapped down-counting timer with a single-source
// interrupt controller. The CPU programs it over the io_* strobes. It raises
// intr through a request/acknowledge handshake on intr/inta.
module io_timer_intc #(
   parameter int unsigned PRESCALE   = 1,
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        io_cs,
   input  logic        io_rd,
   input  logic        io_wr,
   input  logic [31:0] io_addr,
   input  logic [31:0] io_d_in,
   output logic [31:0] io_out,
   output logic        intr,
   input  logic        inta
);

   localparam logic [PRESCALE_W-1:0] PresLast = PRESCALE_W'(PRESCALE - 1);

   localparam logic [2:0] AddrCtrl   = 3'd0;
   localparam logic [2:0] AddrPeriod = 3'd1;
   localparam logic [2:0] AddrCount  = 3'd2;
   localparam logic [2:0] AddrStatus = 3'd3;
   localparam logic [2:0] AddrEvt    = 3'd4;

   typedef enum logic [1:0] {StIdle, StReq, StAck} state_e;

   // CTRL bit positions
   localparam int unsigned CtrlTen = 0;
   localparam int unsigned CtrlIe  = 1;
   localparam int unsigned CtrlAr  = 2;

   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic                  tick;

   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] period_q, period_d;
   logic [31:0] count_q, count_d;
   logic        pend_q, pend_d;
   logic        miss_q, miss_d;
   logic [31:0] evt_q, evt_d;
   logic [31:0] out_q, out_d;
   logic [31:0] rd_data;

   state_e      state_q, state_d;
   logic        intr_q, intr_d;
   logic        ack_clr;

   logic        expire;
   logic        ten_clr;

   logic [2:0]  idx;
   logic        wr_en, rd_en;
   logic        wr_ctrl, wr_period, wr_count, wr_status;
   logic        unused_addr_bits;

   // Only the word index is decoded; the rest of the address is don't-care.
   assign idx              = io_addr[4:2];
   assign unused_addr_bits = ^{io_addr[31:5], io_addr[1:0]};

   assign wr_en     = io_cs & io_wr;
   assign rd_en     = io_cs & io_rd;
   assign wr_ctrl   = wr_en && (idx == AddrCtrl);
   assign wr_period = wr_en && (idx == AddrPeriod);
   assign wr_count  = wr_en && (idx == AddrCount);
   assign wr_status = wr_en && (idx == AddrStatus);

   // -------------------------------------------------------------------------
   // Prescaler: tick fires on the last cycle of each PRESCALE-cycle window.
   // -------------------------------------------------------------------------
   assign tick = (presc_q == PresLast);

   // Next prescaler value: wrap to zero on tick.
   always_comb begin
      presc_d = presc_q + PRESCALE_W'(1);
      if (tick) begin
         presc_d = '0;
      end
   end

   // Prescaler register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   // -------------------------------------------------------------------------
   // Timer datapath and register file next-state.
   // -------------------------------------------------------------------------

   // Counter update; a bus write to COUNT overrides whatever the timer did.
   always_comb begin
      count_d = count_q;
      expire  = 1'b0;
      ten_clr = 1'b0;
      if (tick && ctrl_q[CtrlTen]) begin
         if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
         end else if (count_q == 32'd1) begin
            expire = 1'b1;
            if (ctrl_q[CtrlAr]) begin
               count_d = period_q;
            end else begin
               count_d = '0;
               ten_clr = 1'b1;
            end
         end
      end
      if (wr_count) begin
         count_d = io_d_in;
      end
   end

   // CTRL and PERIOD; a bus write to CTRL beats the one-shot TEN clear.
   always_comb begin
      ctrl_d   = ctrl_q;
      period_d = period_q;
      if (ten_clr) begin
         ctrl_d[CtrlTen] = 1'b0;
      end
      if (wr_ctrl) begin
         ctrl_d = io_d_in[2:0];
      end
      if (wr_period) begin
         period_d = io_d_in;
      end
   end

   // STATUS: clears first, expiry last so a same-cycle expiry wins.
   always_comb begin
      pend_d = pend_q;
      miss_d = miss_q;
      evt_d  = evt_q;
      if (wr_status) begin
         if (io_d_in[0]) begin
            pend_d = 1'b0;
         end
         if (io_d_in[1]) begin
            miss_d = 1'b0;
         end
      end
      if (ack_clr) begin
         pend_d = 1'b0;
         evt_d  = evt_q + 32'd1;
      end
      if (expire) begin
         pend_d = 1'b1;
         if (pend_q) begin
            miss_d = 1'b1;
         end
      end
   end

   // Read mux over pre-update register values.
   always_comb begin
      case (idx)
         AddrCtrl:   rd_data = {29'd0, ctrl_q};
         AddrPeriod: rd_data = period_q;
         AddrCount:  rd_data = count_q;
         AddrStatus: rd_data = {30'd0, miss_q, pend_q};
         AddrEvt:    rd_data = evt_q;
         default:    rd_data = '0;
      endcase
   end

   // Read data is captured on the read strobe and held until the next one.
   always_comb begin
      out_d = out_q;
      if (rd_en) begin
         out_d = rd_data;
      end
   end

   // Register file and read-data register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q   <= '0;
         period_q <= '0;
         count_q  <= '0;
         pend_q   <= 1'b0;
         miss_q   <= 1'b0;
         evt_q    <= '0;
         out_q    <= '0;
      end else begin
         ctrl_q   <= ctrl_d;
         period_q <= period_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
         miss_q   <= miss_d;
         evt_q    <= evt_d;
         out_q    <= out_d;
      end
   end

   // -------------------------------------------------------------------------
   // Interrupt request/acknowledge FSM.
   // -------------------------------------------------------------------------

   // FSM state and registered intr.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         intr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         intr_q  <= intr_d;
      end
   end

   // FSM next-state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (pend_q && ctrl_q[CtrlIe]) begin
               state_d = StReq;
            end
         end
         StReq: begin
            if (inta) begin
               state_d = StAck;
            end else if (!ctrl_q[CtrlIe]) begin
               state_d = StIdle;
            end
         end
         StAck: begin
            if (!inta) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs: intr mirrors residence in StReq; ack clears PEND and counts.
   always_comb begin
      intr_d  = (state_d == StReq);
      ack_clr = (state_q == StReq) && inta;
   end

   assign io_out = out_q;
   assign intr   = intr_q;

endmodule

// File: tb/tb_io_timer_intc.sv
// Bench for io_timer_intc: a directed per-cycle vector table, an async reset
// sequence, then random bus/inta traffic checked against a behavioural model.
module tb_io_timer_intc;

   localparam int unsigned P = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        io_cs, io_rd, io_wr, inta;
   logic [31:0] io_addr, io_d_in;
   logic [31:0] io_out;
   logic        intr;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   io_timer_intc #(
      .PRESCALE   (P),
      .PRESCALE_W (16)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .io_cs   (io_cs),
      .io_rd   (io_rd),
      .io_wr   (io_wr),
      .io_addr (io_addr),
      .io_d_in (io_d_in),
      .io_out  (io_out),
      .intr    (intr),
      .inta    (inta)
   );

   typedef struct {
      logic        cs;
      logic        rd;
      logic        wr;
      logic [2:0]  a;
      logic [31:0] d;
      logic        ia;
      logic [31:0] eo;
      logic        ei;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t vrow(input logic cs, input logic rd, input logic wr,
                                 input logic [2:0] a, input logic [31:0] d,
                                 input logic ia, input logic [31:0] eo, input logic ei);
      vec_t v;
      v.cs = cs; v.rd = rd; v.wr = wr; v.a = a; v.d = d; v.ia = ia; v.eo = eo; v.ei = ei;
      return v;
   endfunction

   function automatic vec_t vr(input logic [2:0] a, input logic ia, input logic [31:0] eo,
                               input logic ei);
      return vrow(1'b1, 1'b1, 1'b0, a, 32'd0, ia, eo, ei);
   endfunction

   function automatic vec_t vw(input logic [2:0] a, input logic [31:0] d, input logic ia,
                               input logic [31:0] eo, input logic ei);
      return vrow(1'b1, 1'b0, 1'b1, a, d, ia, eo, ei);
   endfunction

   function automatic vec_t vn(input logic ia, input logic [31:0] eo, input logic ei);
      return vrow(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, ia, eo, ei);
   endfunction

   // ---------------- behavioural reference model ----------------
   logic [2:0]  m_ctrl;
   logic [31:0] m_period, m_count, m_evt, m_out;
   logic        m_pend, m_miss, m_intr;
   bit          m_req, m_wait;
   int unsigned m_cyc;

   task automatic model_reset();
      m_ctrl = '0; m_period = '0; m_count = '0; m_evt = '0; m_out = '0;
      m_pend = 0; m_miss = 0; m_intr = 0; m_req = 0; m_wait = 0; m_cyc = 0;
   endtask

   // What one clock edge does, given this cycle's bus and inta values.
   task automatic model_step(input logic cs, input logic rd, input logic wr,
                             input logic [2:0] a, input logic [31:0] d, input logic ia);
      logic [31:0] regs [8];
      bit tick, fire, ack, raise, drop, leave;
      foreach (regs[i]) regs[i] = '0;
      regs[0] = {29'd0, m_ctrl};
      regs[1] = m_period;
      regs[2] = m_count;
      regs[3] = {30'd0, m_miss, m_pend};
      regs[4] = m_evt;
      tick  = (m_cyc % P) == (P - 1);
      m_cyc++;
      fire  = tick && m_ctrl[0] && (m_count == 32'd1);
      ack   = m_req && ia;
      raise = !m_req && !m_wait && m_pend && m_ctrl[1];
      drop  = m_req && !ia && !m_ctrl[1];
      leave = m_wait && !ia;
      if (tick && m_ctrl[0] && m_count > 32'd1) m_count = m_count - 1;
      else if (fire) begin
         if (m_ctrl[2]) m_count = m_period;
         else begin
            m_count   = 0;
            m_ctrl[0] = 1'b0;
         end
      end
      if (cs && wr && a == 3'd3) begin
         if (d[0]) m_pend = 0;
         if (d[1]) m_miss = 0;
      end
      if (ack) begin
         m_pend = 0;
         m_evt  = m_evt + 1;
      end
      if (fire) begin
         if (regs[3][0]) m_miss = 1;
         m_pend = 1;
      end
      if (cs && wr) begin
         if (a == 3'd0) m_ctrl = d[2:0];
         if (a == 3'd1) m_period = d;
         if (a == 3'd2) m_count = d;
      end
      if (raise) m_req = 1;
      if (ack) begin
         m_req  = 0;
         m_wait = 1;
      end
      if (drop) m_req = 0;
      if (leave) m_wait = 0;
      m_intr = m_req;
      if (cs && rd) m_out = regs[a];
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic cs, input logic rd, input logic wr, input logic [2:0] a,
                        input logic [31:0] d, input logic ia);
      logic [31:0] addr;
      addr      = $urandom;
      addr[4:2] = a;
      io_cs = cs; io_rd = rd; io_wr = wr; io_addr = addr; io_d_in = d; inta = ia;
      model_step(cs, rd, wr, a, d, ia);
   endtask

   // One cycle checked against the model.
   task automatic model_cycle(input string tag, input logic cs, input logic rd, input logic wr,
                              input logic [2:0] a, input logic [31:0] d, input logic ia);
      drive(cs, rd, wr, a, d, ia);
      @(posedge clk);
      #1;
      check($sformatf("%s io_out", tag), io_out, m_out);
      check($sformatf("%s intr", tag), {31'd0, intr}, {31'd0, m_intr});
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      io_cs = 0; io_rd = 0; io_wr = 0; io_addr = '0; io_d_in = '0; inta = 0;
      model_reset();

      // Reset / readback
      for (int i = 0; i < 8; i++) tbl.push_back(vr(3'(i), 0, 32'h0, 0));
      tbl.push_back(vw(3'd1, 32'hDEADBEEF, 0, 32'h0, 0));
      tbl.push_back(vr(3'd1, 0, 32'hDEADBEEF, 0));
      tbl.push_back(vrow(1'b0, 1'b1, 1'b1, 3'd1, 32'h0, 0, 32'hDEADBEEF, 0));
      // One-shot, IE=0
      tbl.push_back(vw(3'd2, 32'd3, 0, 32'hDEADBEEF, 0));
      tbl.push_back(vw(3'd0, 32'h1, 0, 32'hDEADBEEF, 0));
      for (int i = 0; i < 3; i++) tbl.push_back(vn(0, 32'hDEADBEEF, 0));
      tbl.push_back(vr(3'd3, 0, 32'h1, 0));
      tbl.push_back(vr(3'd2, 0, 32'h0, 0));
      tbl.push_back(vr(3'd0, 0, 32'h0, 0));
      tbl.push_back(vr(3'd1, 0, 32'hDEADBEEF, 0));
      tbl.push_back(vw(3'd3, 32'h1, 0, 32'hDEADBEEF, 0));
      tbl.push_back(vr(3'd3, 0, 32'h0, 0));
      // Periodic interrupt
      tbl.push_back(vw(3'd1, 32'd4, 0, 32'h0, 0));
      tbl.push_back(vw(3'd2, 32'd4, 0, 32'h0, 0));
      tbl.push_back(vw(3'd0, 32'h7, 0, 32'h0, 0));
      for (int i = 0; i < 4; i++) tbl.push_back(vn(0, 32'h0, 0));
      tbl.push_back(vn(0, 32'h0, 1));
      tbl.push_back(vn(1, 32'h0, 0));
      tbl.push_back(vn(0, 32'h0, 0));
      tbl.push_back(vn(0, 32'h0, 0));
      tbl.push_back(vr(3'd4, 0, 32'd1, 1));
      tbl.push_back(vr(3'd3, 1, 32'h1, 0));
      tbl.push_back(vn(0, 32'h1, 0));
      tbl.push_back(vr(3'd4, 0, 32'd2, 0));
      tbl.push_back(vn(0, 32'd2, 1));
      tbl.push_back(vw(3'd0, 32'h0, 1, 32'd2, 0));
      tbl.push_back(vn(0, 32'd2, 0));
      tbl.push_back(vr(3'd4, 0, 32'd3, 0));
      // Miss
      tbl.push_back(vw(3'd1, 32'd2, 0, 32'd3, 0));
      tbl.push_back(vw(3'd2, 32'd2, 0, 32'd3, 0));
      tbl.push_back(vw(3'd0, 32'h5, 0, 32'd3, 0));
      for (int i = 0; i < 4; i++) tbl.push_back(vn(0, 32'd3, 0));
      tbl.push_back(vr(3'd3, 0, 32'h3, 0));
      tbl.push_back(vw(3'd3, 32'h3, 0, 32'h3, 0));
      tbl.push_back(vrow(1'b1, 1'b1, 1'b1, 3'd3, 32'h3, 0, 32'h3, 0));
      tbl.push_back(vr(3'd3, 0, 32'h0, 0));
      tbl.push_back(vw(3'd0, 32'h0, 0, 32'h0, 0));
      tbl.push_back(vr(3'd3, 0, 32'h1, 0));
      tbl.push_back(vw(3'd3, 32'h3, 0, 32'h1, 0));
      tbl.push_back(vr(3'd3, 0, 32'h0, 0));
      // IE drop while requesting
      tbl.push_back(vw(3'd0, 32'h3, 0, 32'h0, 0));
      tbl.push_back(vn(0, 32'h0, 0));
      tbl.push_back(vn(0, 32'h0, 1));
      tbl.push_back(vw(3'd0, 32'h5, 0, 32'h0, 1));
      tbl.push_back(vn(0, 32'h0, 0));
      tbl.push_back(vr(3'd3, 0, 32'h1, 0));
      tbl.push_back(vw(3'd0, 32'h2, 0, 32'h1, 0));
      tbl.push_back(vn(0, 32'h1, 1));
      tbl.push_back(vn(0, 32'h1, 1));

      repeat (3) @(negedge clk);
      reset = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].cs, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].ia);
         @(posedge clk);
         #1;
         check($sformatf("row%0d io_out", i), io_out, tbl[i].eo);
         check($sformatf("row%0d intr", i), {31'd0, intr}, {31'd0, tbl[i].ei});
         @(negedge clk);
      end

      // Async reset while intr is high: everything drops without a clock edge.
      io_cs = 0; io_rd = 0; io_wr = 0; inta = 0;
      #2;
      reset = 1'b0;
      #1;
      check("async intr", {31'd0, intr}, 32'd0);
      check("async io_out", io_out, 32'd0);
      @(posedge clk);
      #1;
      check("async held intr", {31'd0, intr}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      model_reset();

      for (int i = 0; i < 8; i++) model_cycle($sformatf("post_rst rd%0d", i), 1, 1, 0, 3'(i), 0, 0);
      for (int i = 0; i < 6; i++) model_cycle("post_rst idle", 0, 0, 0, 3'd0, 0, 0);

      // Random traffic with small counts so expiries and interrupts happen often.
      for (int i = 0; i < 3000; i++) begin
         logic        cs, rd, wr, ia;
         logic [2:0]  a;
         logic [31:0] d;
         cs = ($urandom_range(0, 3) != 0);
         rd = $urandom_range(0, 1) != 0;
         wr = ($urandom_range(0, 4) == 0);
         a  = 3'($urandom_range(0, 7));
         ia = ($urandom_range(0, 2) == 0);
         case (a)
            3'd1, 3'd2: d = $urandom_range(0, 6);
            3'd3:       d = $urandom_range(0, 3);
            default:    d = $urandom;
         endcase
         model_cycle($sformatf("rand%0d", i), cs, rd, wr, a, d, ia);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
